// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand width, key codes and entry FSM states.
package calc_pkg;

    localparam int W        = 14;
    localparam int N_DIGITS = 4;

    localparam logic [3:0] K_ADD = 4'b1101;
    localparam logic [3:0] K_SUB = 4'b1110;
    localparam logic [3:0] K_EQ  = 4'b1111;
    localparam logic [3:0] K_CLR = 4'b1100;

    typedef enum logic [1:0] {
        S_OP1  = 2'd0,
        S_OP2  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Decimal digit keys are 0..9; 1010/1011 are unused codes.
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    // Operator keys double as the op_val code handed to alu_core.
    function automatic logic is_operator(input logic [3:0] k);
        return (k == K_ADD) || (k == K_SUB);
    endfunction

endpackage

// File: rtl/dec_digit_acc.sv
// Decimal accumulator (acc*10 + digit) with a saturating digit counter.
// Shared between both operands; the entry FSM decides which operand it feeds.
module dec_digit_acc
    import calc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         add,
    input  logic [3:0]   digit,
    output logic [W-1:0] acc,
    output logic [2:0]   cnt,
    output logic [W-1:0] acc_nxt,
    output logic [2:0]   cnt_nxt
);

    logic [W-1:0] digit_ext;

    assign digit_ext = W'(digit);

    // Next value: clear beats load beats accumulate; digits past the limit are dropped.
    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        if (clear) begin
            acc_nxt = '0;
            cnt_nxt = '0;
        end else if (load) begin
            acc_nxt = digit_ext;
            cnt_nxt = 3'd1;
        end else if (add && (cnt < 3'(N_DIGITS))) begin
            acc_nxt = (acc << 3) + (acc << 1) + digit_ext;
            cnt_nxt = cnt + 3'd1;
        end
    end

    // Accumulator and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/operand_entry_ctrl.sv
// Keypad front end: builds two decimal operands and an operator for alu_core.
module operand_entry_ctrl
    import calc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   key_code,
    input  logic         key_valid,
    output logic [W-1:0] op1,
    output logic [W-1:0] op2,
    output logic [3:0]   op_val,
    output logic         calc_done,
    output logic         eq_pulse,
    output logic [W-1:0] disp_val,
    output logic [2:0]   dig_cnt
);

    state_t       state, state_nxt;
    logic [W-1:0] op1_nxt, op2_nxt;
    logic [3:0]   op_val_nxt;
    logic         eq_nxt;
    logic         acc_clear, acc_load, acc_add;
    logic         wr_op1, wr_op2, zero_op1, zero_op2;
    logic [W-1:0] acc_nxt;
    logic [2:0]   cnt_nxt;
    logic         key_dig, key_opr, key_eq, key_clr;

    assign key_dig = key_valid && is_digit(key_code);
    assign key_opr = key_valid && is_operator(key_code);
    assign key_eq  = key_valid && (key_code == K_EQ);
    assign key_clr = key_valid && (key_code == K_CLR);

    // The accumulator register doubles as the live display value and digit count.
    dec_digit_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .load    (acc_load),
        .add     (acc_add),
        .digit   (key_code),
        .acc     (disp_val),
        .cnt     (dig_cnt),
        .acc_nxt (acc_nxt),
        .cnt_nxt (cnt_nxt)
    );

    // Control decisions: state transitions, accumulator commands, operand write enables.
    always_comb begin
        state_nxt  = state;
        op_val_nxt = op_val;
        eq_nxt     = 1'b0;
        acc_clear  = 1'b0;
        acc_load   = 1'b0;
        acc_add    = 1'b0;
        wr_op1     = 1'b0;
        wr_op2     = 1'b0;
        zero_op1   = 1'b0;
        zero_op2   = 1'b0;
        if (key_clr) begin
            state_nxt  = S_OP1;
            op_val_nxt = 4'b0000;
            acc_clear  = 1'b1;
            zero_op1   = 1'b1;
            zero_op2   = 1'b1;
        end else begin
            unique case (state)
                S_OP1: begin
                    if (key_dig) begin
                        acc_add = 1'b1;
                        wr_op1  = 1'b1;
                    end else if (key_opr) begin
                        op_val_nxt = key_code;
                        acc_clear  = 1'b1;
                        zero_op2   = 1'b1;
                        state_nxt  = S_OP2;
                    end
                end
                S_OP2: begin
                    if (key_dig) begin
                        acc_add = 1'b1;
                        wr_op2  = 1'b1;
                    end else if (key_opr && (dig_cnt == 3'd0)) begin
                        op_val_nxt = key_code;
                    end else if (key_eq) begin
                        state_nxt = S_DONE;
                        eq_nxt    = 1'b1;
                    end
                end
                S_DONE: begin
                    if (key_dig) begin
                        acc_load   = 1'b1;
                        wr_op1     = 1'b1;
                        zero_op2   = 1'b1;
                        op_val_nxt = 4'b0000;
                        state_nxt  = S_OP1;
                    end
                end
                default: begin
                    state_nxt = S_OP1;
                end
            endcase
        end
    end

    // Operand data path: take the accumulator's next value for the operand being edited.
    always_comb begin
        op1_nxt = op1;
        op2_nxt = op2;
        if (zero_op1) begin
            op1_nxt = '0;
        end else if (wr_op1) begin
            op1_nxt = acc_nxt;
        end
        if (zero_op2) begin
            op2_nxt = '0;
        end else if (wr_op2) begin
            op2_nxt = acc_nxt;
        end
    end

    // State and registered outputs; calc_done follows the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OP1;
            op1       <= '0;
            op2       <= '0;
            op_val    <= 4'b0000;
            calc_done <= 1'b0;
            eq_pulse  <= 1'b0;
        end else begin
            state     <= state_nxt;
            op1       <= op1_nxt;
            op2       <= op2_nxt;
            op_val    <= op_val_nxt;
            calc_done <= (state_nxt == S_DONE);
            eq_pulse  <= eq_nxt;
        end
    end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Self-checking bench for operand_entry_ctrl: behavioural model plus literal checks.
module tb_operand_entry_ctrl;

    localparam int KEY_CLR = 12;
    localparam int KEY_ADD = 13;
    localparam int KEY_SUB = 14;
    localparam int KEY_EQ  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [13:0] op1, op2, disp_val;
    logic [3:0]  op_val;
    logic        calc_done, eq_pulse;
    logic [2:0]  dig_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // Model: plain decimal numbers and two flags describing where entry stands.
    int m_op1 = 0, m_op2 = 0, m_opv = 0, m_cnt = 0;
    bit m_second = 0, m_done = 0, m_eq = 0;

    operand_entry_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .op1       (op1),
        .op2       (op2),
        .op_val    (op_val),
        .calc_done (calc_done),
        .eq_pulse  (eq_pulse),
        .disp_val  (disp_val),
        .dig_cnt   (dig_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmpField(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Predict the outputs after the coming clock edge from the calculator rules.
    task automatic modelKey(input bit rstv, input bit valid, input int code);
        m_eq = 0;
        if (rstv || (valid && code == KEY_CLR)) begin
            m_op1 = 0; m_op2 = 0; m_opv = 0; m_cnt = 0;
            m_second = 0; m_done = 0;
        end else if (valid) begin
            if (code <= 9) begin
                if (m_done) begin
                    m_op1 = code; m_op2 = 0; m_opv = 0; m_cnt = 1;
                    m_done = 0; m_second = 0;
                end else if (m_cnt < 4) begin
                    if (m_second) m_op2 = m_op2 * 10 + code;
                    else          m_op1 = m_op1 * 10 + code;
                    m_cnt++;
                end
            end else if (code == KEY_ADD || code == KEY_SUB) begin
                if (!m_second && !m_done) begin
                    m_opv = code; m_cnt = 0; m_op2 = 0; m_second = 1;
                end else if (m_second && !m_done && m_cnt == 0) begin
                    m_opv = code;
                end
            end else if (code == KEY_EQ) begin
                if (m_second && !m_done) begin
                    m_done = 1;
                    m_eq = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit rstv, input bit valid, input int code);
        @(negedge clk);
        rst       = rstv;
        key_valid = valid;
        key_code  = 4'(code);
        modelKey(rstv, valid, code);
    endtask

    task automatic pressKey(input int code);
        applyStimulus(0, 1, code);
        applyStimulus(0, 0, 0);
    endtask

    task automatic checkOutput();
        cmpField("op1", 32'(op1), m_op1);
        cmpField("op2", 32'(op2), m_op2);
        cmpField("op_val", 32'(op_val), m_opv);
        cmpField("dig_cnt", 32'(dig_cnt), m_cnt);
        cmpField("calc_done", 32'(calc_done), 32'(m_done));
        cmpField("eq_pulse", 32'(eq_pulse), 32'(m_eq));
        cmpField("disp_val", 32'(disp_val), (m_second || m_done) ? m_op2 : m_op1);
    endtask

    // Every cycle, shortly after the rising edge, compare the DUT with the model.
    always @(posedge clk) begin
        #1;
        if (check_en) checkOutput();
    end

    initial begin
        $display("[TB] operand_entry_ctrl bench start");

        // Reset wins over a coincident digit strobe.
        applyStimulus(1, 1, 5);
        check_en = 1'b1;
        applyStimulus(0, 0, 0);
        cmpField("lit_rst_op1", 32'(op1), 0);
        cmpField("lit_rst_cnt", 32'(dig_cnt), 0);
        cmpField("lit_rst_done", 32'(calc_done), 0);

        // Five digits, with ignored codes and a non-strobed digit sprinkled in.
        pressKey(1); pressKey(10); pressKey(2);
        applyStimulus(0, 0, 7);
        pressKey(3); pressKey(11); pressKey(4); pressKey(5);
        cmpField("lit_trunc_op1", 32'(op1), 1234);
        cmpField("lit_trunc_cnt", 32'(dig_cnt), 4);
        cmpField("lit_trunc_disp", 32'(disp_val), 1234);
        pressKey(KEY_EQ);
        cmpField("lit_eq_in_op1", 32'(calc_done), 0);

        // Leading zeros count as digits.
        applyStimulus(1, 0, 0);
        pressKey(0); pressKey(0); pressKey(1);
        cmpField("lit_lz_op1", 32'(op1), 1);
        cmpField("lit_lz_cnt", 32'(dig_cnt), 3);

        // Maximum operand and a complete addition.
        applyStimulus(1, 0, 0);
        pressKey(9); pressKey(9); pressKey(9); pressKey(9);
        pressKey(KEY_ADD); pressKey(1); pressKey(KEY_EQ);
        cmpField("lit_max_op1", 32'(op1), 9999);
        cmpField("lit_max_op2", 32'(op2), 1);
        cmpField("lit_max_opv", 32'(op_val), 13);
        cmpField("lit_max_eq", 32'(eq_pulse), 1);
        applyStimulus(0, 0, 0);
        cmpField("lit_max_done", 32'(calc_done), 1);
        cmpField("lit_max_eq_gone", 32'(eq_pulse), 0);

        // Operator replaced while op2 has no digits yet.
        pressKey(KEY_CLR);
        pressKey(5); pressKey(KEY_SUB); pressKey(KEY_ADD); pressKey(3); pressKey(KEY_EQ);
        cmpField("lit_repl_opv", 32'(op_val), 13);
        cmpField("lit_repl_op2", 32'(op2), 3);

        // Operator locked once op2 has digits; then '=' twice and a new digit.
        pressKey(KEY_CLR);
        pressKey(7); pressKey(KEY_SUB); pressKey(2); pressKey(KEY_ADD);
        cmpField("lit_lock_opv", 32'(op_val), 14);
        pressKey(KEY_EQ); pressKey(KEY_EQ); pressKey(KEY_SUB);
        cmpField("lit_done_eq", 32'(eq_pulse), 0);
        cmpField("lit_done_held", 32'(op2), 2);
        pressKey(4);
        cmpField("lit_new_op1", 32'(op1), 4);
        cmpField("lit_new_op2", 32'(op2), 0);
        cmpField("lit_new_opv", 32'(op_val), 0);
        cmpField("lit_new_done", 32'(calc_done), 0);
        cmpField("lit_new_cnt", 32'(dig_cnt), 1);

        // Op2 truncation at four digits.
        pressKey(KEY_CLR);
        pressKey(1); pressKey(KEY_ADD);
        pressKey(9); pressKey(8); pressKey(7); pressKey(6); pressKey(5);
        cmpField("lit_op2_trunc", 32'(op2), 9876);

        // Clear mid-op2 behaves exactly like reset.
        pressKey(KEY_CLR);
        pressKey(6); pressKey(KEY_ADD); pressKey(8);
        pressKey(KEY_CLR);
        cmpField("lit_clr_op1", 32'(op1), 0);
        cmpField("lit_clr_op2", 32'(op2), 0);
        cmpField("lit_clr_opv", 32'(op_val), 0);
        cmpField("lit_clr_disp", 32'(disp_val), 0);
        pressKey(2);
        cmpField("lit_clr_after", 32'(op1), 2);

        // Reset with a coincident digit in the middle of entry.
        pressKey(KEY_ADD); pressKey(3);
        applyStimulus(1, 1, 9);
        applyStimulus(0, 0, 0);
        cmpField("lit_rst2_op1", 32'(op1), 0);
        cmpField("lit_rst2_opv", 32'(op_val), 0);

        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
